// File: rtl/ccff_stream_loader.sv
// Streams bitstream words into NUM_CHAINS parallel configuration chains and,
// optionally, reads the previous chain contents back out word by word.
module ccff_stream_loader #(
  parameter int unsigned NUM_CHAINS = 1,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CHAIN_LEN  = 64
) (
  input  logic                  prog_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_W-1:0]     rb_data,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  ccff_shift_en,
  output logic                  busy,
  output logic                  done
);

  // Division guards keep illegal parameter sets reaching the check below
  // instead of failing on a divide-by-zero first.
  localparam int unsigned NC_SAFE   = (NUM_CHAINS == 0) ? 1 : NUM_CHAINS;
  localparam int unsigned BPW       = DATA_W / NC_SAFE;
  localparam int unsigned BPW_SAFE  = (BPW == 0) ? 1 : BPW;
  localparam int unsigned WORDS     = CHAIN_LEN / BPW_SAFE;
  localparam int unsigned WCNT_W    = $clog2(WORDS + 1);
  localparam int unsigned BCNT_W    = (BPW > 1) ? $clog2(BPW) : 1;
  localparam bit          PARAMS_OK = (NUM_CHAINS != 0) && (BPW != 0) &&
                                      ((DATA_W % NC_SAFE) == 0) &&
                                      ((CHAIN_LEN % BPW_SAFE) == 0) &&
                                      (WORDS != 0);

  // Refuse to elaborate with a word that does not split evenly over the chains
  // or a chain length that is not a whole number of words.
  if (!PARAMS_OK) begin : g_param_check
    $error("ccff_stream_loader: illegal NUM_CHAINS/DATA_W/CHAIN_LEN combination");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_mode;
  logic [WCNT_W-1:0]     r_words;
  logic [BCNT_W-1:0]     r_bit;
  logic [DATA_W-1:0]     r_sreg;
  logic [DATA_W-1:0]     r_rb_sreg;
  logic [DATA_W-1:0]     r_rb_data;
  logic                  r_rb_valid;
  logic [NUM_CHAINS-1:0] r_head;
  logic                  r_shift_en;
  logic                  r_in_ready;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic                  w_mode_nxt;
  logic                  w_hs;
  logic                  w_last_bit;
  logic [WCNT_W-1:0]     w_words_inc;
  logic                  w_rb_set;
  logic                  w_rb_valid_nxt;
  logic [DATA_W-1:0]     w_rb_word;

  assign in_ready      = r_in_ready;
  assign rb_data       = r_rb_data;
  assign rb_valid      = r_rb_valid;
  assign ccff_head     = r_head;
  assign ccff_shift_en = r_shift_en;
  assign busy          = r_busy;
  assign done          = r_done;

  // Readback word with this cycle's tail bits inserted at the top; after BPW
  // cycles the first-sampled tail bits sit in the low NUM_CHAINS bits.
  assign w_rb_word = (r_rb_sreg >> NUM_CHAINS) |
                     (DATA_W'(ccff_tail) << (DATA_W - NUM_CHAINS));

  // State register.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the next readback-valid value used by the output regs.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_hs        = 1'b0;
    w_rb_set    = 1'b0;
    w_last_bit  = (r_bit == BCNT_W'(BPW - 1));
    w_words_inc = r_words + WCNT_W'(1);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_LOAD;
          w_mode_nxt  = mode;
        end
      end
      S_LOAD: begin
        if (in_valid && r_in_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last_bit) begin
          w_rb_set = r_mode;
          if (w_words_inc < WCNT_W'(WORDS)) begin
            w_state_nxt = S_LOAD;
          end else if (r_mode) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DRAIN: begin
        if (!r_rb_valid) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_rb_set) begin
      w_rb_valid_nxt = 1'b1;
    end else if (r_rb_valid && rb_ready) begin
      w_rb_valid_nxt = 1'b0;
    end else begin
      w_rb_valid_nxt = r_rb_valid;
    end
  end

  // Registered outputs are computed from next-state values so they line up
  // with the state they describe.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      r_mode     <= 1'b0;
      r_in_ready <= 1'b0;
      r_shift_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rb_valid <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_in_ready <= (w_state_nxt == S_LOAD) && !(w_mode_nxt && w_rb_valid_nxt);
      r_shift_en <= (w_state_nxt == S_SHIFT);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_rb_valid <= w_rb_valid_nxt;
    end
  end

  // Word/bit counters, serialiser, readback deserialiser.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      r_words   <= '0;
      r_bit     <= '0;
      r_sreg    <= '0;
      r_rb_sreg <= '0;
      r_rb_data <= '0;
      r_head    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_words <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_head <= in_data[NUM_CHAINS-1:0];
            r_sreg <= in_data >> NUM_CHAINS;
            r_bit  <= '0;
          end
        end
        S_SHIFT: begin
          r_rb_sreg <= w_rb_word;
          if (w_last_bit) begin
            r_head  <= '0;
            r_words <= w_words_inc;
            if (r_mode) begin
              r_rb_data <= w_rb_word;
            end
          end else begin
            r_head <= r_sreg[NUM_CHAINS-1:0];
            r_sreg <= r_sreg >> NUM_CHAINS;
            r_bit  <= r_bit + BCNT_W'(1);
          end
        end
        default: begin
          r_head <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: default single-chain instance with a
// behavioural 64-flop chain, plus a 2-chain/4-deep instance for head ordering.
module tb_ccff_stream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default-parameter instance
  logic       a_reset, a_start, a_mode;
  logic [7:0] a_in_data;
  logic       a_in_valid, a_in_ready;
  logic [7:0] a_rb_data;
  logic       a_rb_valid, a_rb_ready;
  logic [0:0] a_head, a_tail;
  logic       a_shift_en, a_busy, a_done;

  ccff_stream_loader dut_a (
    .prog_clk(clk), .reset(a_reset), .start(a_start), .mode(a_mode),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .rb_data(a_rb_data), .rb_valid(a_rb_valid), .rb_ready(a_rb_ready),
    .ccff_head(a_head), .ccff_tail(a_tail), .ccff_shift_en(a_shift_en),
    .busy(a_busy), .done(a_done)
  );

  // Two chains of four flops
  logic       b_reset, b_start, b_mode;
  logic [7:0] b_in_data;
  logic       b_in_valid, b_in_ready;
  logic [7:0] b_rb_data;
  logic       b_rb_valid, b_rb_ready;
  logic [1:0] b_head, b_tail;
  logic       b_shift_en, b_busy, b_done;

  ccff_stream_loader #(.NUM_CHAINS(2), .DATA_W(8), .CHAIN_LEN(4)) dut_b (
    .prog_clk(clk), .reset(b_reset), .start(b_start), .mode(b_mode),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rb_data(b_rb_data), .rb_valid(b_rb_valid), .rb_ready(b_rb_ready),
    .ccff_head(b_head), .ccff_tail(b_tail), .ccff_shift_en(b_shift_en),
    .busy(b_busy), .done(b_done)
  );
  assign b_tail = 2'b00;

  // Chain model: bit 0 is next to the head, bit 63 drives the tail.
  logic [63:0] chain_a = '0;
  int          a_shift_cnt = 0;
  always @(posedge clk) begin
    if (a_shift_en) begin
      chain_a     <= {chain_a[62:0], a_head[0]};
      a_shift_cnt <= a_shift_cnt + 1;
    end
  end
  assign a_tail[0] = chain_a[63];

  logic [7:0] a_words [8];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  logic [1:0] exp_head [$];
  int a_first_hs, a_done_at, a_stall_viol, a_timeout;

  function automatic logic [7:0] snap_word(input logic [63:0] s, input int w);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = s[63 - (8 * w + k)];
    return r;
  endfunction

  function automatic logic [63:0] exp_chain();
    logic [63:0] r;
    logic [7:0]  wd;
    for (int i = 0; i < 64; i++) begin
      wd = a_words[i / 8];
      r[63 - i] = wd[i % 8];
    end
    return r;
  endfunction

  // Drive one load on dut_a; readback words go to got_q, expected ones to exp_q.
  task automatic load_a(input logic mode, input int stall_len, input bit rand_valid,
                        input bit extra_start, input bit abort);
    int t = 0;
    int widx = 0;
    int hold = 0;
    int wshift = 0;
    bit stalled_once = 0;
    bit fin = 0;
    logic [63:0] snap;
    snap = chain_a;
    exp_q.delete();
    got_q.delete();
    a_first_hs = -1; a_done_at = -1; a_stall_viol = 0; a_timeout = 0;
    @(negedge clk); a_start = 1'b1; a_mode = mode;
    @(negedge clk); a_start = 1'b0;
    while (!fin && t < 3000) begin
      a_in_valid = (widx < 8) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      a_in_data  = a_words[widx % 8];
      if (stall_len > 0 && !stalled_once && a_rb_valid) begin
        hold = stall_len;
        stalled_once = 1;
      end
      if (hold > 0) begin
        a_rb_ready = 1'b0;
        if (a_in_ready || a_shift_en) a_stall_viol++;
        hold--;
      end else begin
        a_rb_ready = 1'b1;
      end
      a_start = extra_start && (t == 10);
      if (a_in_valid && a_in_ready) begin
        if (a_first_hs < 0) a_first_hs = t;
        if (mode) exp_q.push_back(snap_word(snap, widx));
        widx++;
      end
      if (a_rb_valid && a_rb_ready) got_q.push_back(a_rb_data);
      if (a_shift_en && widx == 2) begin
        wshift++;
        if (abort && wshift == 3) begin
          a_reset = 1'b1;
          a_in_valid = 1'b0;
          @(negedge clk);
          return;
        end
      end
      if (a_done) begin
        a_done_at = t;
        fin = 1;
      end
      @(negedge clk);
      t++;
    end
    a_in_valid = 1'b0;
    a_rb_ready = 1'b1;
    a_start = 1'b0;
    if (!fin) a_timeout = 1;
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    a_start = 1'b1; b_start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({a_in_ready, a_rb_valid, a_rb_data, a_head, a_shift_en, a_busy, a_done} !== 14'h0) begin
      bad++;
      $display("FAIL reset_a: got %h want 0",
               {a_in_ready, a_rb_valid, a_rb_data, a_head, a_shift_en, a_busy, a_done});
    end
    total++;
    if ({b_in_ready, b_rb_valid, b_rb_data, b_head, b_shift_en, b_busy, b_done} !== 15'h0) begin
      bad++;
      $display("FAIL reset_b: got %h want 0",
               {b_in_ready, b_rb_valid, b_rb_data, b_head, b_shift_en, b_busy, b_done});
    end
    a_start = 1'b0; b_start = 1'b0;
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_over_start: busy got %b want 0", a_busy);
    end
  endtask

  task automatic test_two_chains();
    int t = 0;
    int nshift = 0;
    int last_shift = -1;
    int done_t = -1;
    int stray = 0;
    bit sent = 0;
    logic [7:0] w;
    logic [1:0] eh;
    b_mode = 1'b0;
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (done_t < 0 && t < 60) begin
      b_in_valid = !sent;
      b_in_data  = 8'hB4;
      if (b_in_valid && b_in_ready) begin
        sent = 1;
        w = b_in_data;
        for (int k = 0; k < 4; k++) exp_head.push_back({w[2 * k + 1], w[2 * k]});
      end
      if (b_shift_en) begin
        eh = (exp_head.size() > 0) ? exp_head.pop_front() : 2'bxx;
        total++;
        if (b_head !== eh) begin
          bad++;
          $display("FAIL head_shift%0d: got %b want %b", nshift, b_head, eh);
        end
        nshift++;
        last_shift = t;
      end else if (b_head !== 2'b00) begin
        stray++;
      end
      if (b_done) done_t = t;
      @(negedge clk);
      t++;
    end
    b_in_valid = 1'b0;
    total++;
    if (nshift !== 4 || stray !== 0) begin
      bad++;
      $display("FAIL two_chain_shifts: got %0d shifts %0d stray heads want 4 and 0", nshift, stray);
    end
    total++;
    if (done_t !== last_shift + 1) begin
      bad++;
      $display("FAIL two_chain_done: got cycle %0d want %0d", done_t, last_shift + 1);
    end
  endtask

  task automatic test_stream();
    int c0;
    for (int i = 0; i < 8; i++) a_words[i] = 8'(i + 1);
    c0 = a_shift_cnt;
    load_a(1'b0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (a_timeout !== 0) begin
      bad++;
      $display("FAIL stream_timeout: got %0d want 0", a_timeout);
    end
    total++;
    if (a_shift_cnt - c0 !== 64) begin
      bad++;
      $display("FAIL stream_shifts: got %0d want 64", a_shift_cnt - c0);
    end
    total++;
    if (a_done_at - a_first_hs !== 72) begin
      bad++;
      $display("FAIL stream_done_cycle: got %0d want 72", a_done_at - a_first_hs);
    end
    total++;
    if (chain_a !== exp_chain()) begin
      bad++;
      $display("FAIL stream_chain: got %h want %h", chain_a, exp_chain());
    end
    total++;
    if ({a_busy, a_done} !== 2'b00) begin
      bad++;
      $display("FAIL stream_idle_after: got %b want 00", {a_busy, a_done});
    end
  endtask

  // Compare the readback scoreboard for the last load.
  task automatic test_readback();
    logic [7:0] e;
    for (int i = 0; i < 8; i++) a_words[i] = 8'(8'h11 * (i + 1));
    load_a(1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) a_words[i] = 8'hFF;
    load_a(1'b1, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (got_q.size() !== 8 || exp_q.size() !== 8 || a_timeout !== 0) begin
      bad++;
      $display("FAIL readback_count: got %0d want 8", got_q.size());
    end
    for (int i = 0; i < 8 && got_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[0] !== e || e !== 8'(8'h11 * (i + 1))) begin
        bad++;
        $display("FAIL readback_word%0d: got %h want %h", i, got_q[0], 8'(8'h11 * (i + 1)));
      end
      void'(got_q.pop_front());
    end
    total++;
    if (chain_a !== {64{1'b1}}) begin
      bad++;
      $display("FAIL readback_chain: got %h want all ones", chain_a);
    end
  endtask

  task automatic test_rb_stall();
    logic [7:0] e;
    int n;
    for (int i = 0; i < 8; i++) a_words[i] = 8'($urandom_range(0, 255));
    load_a(1'b1, 20, 1'b0, 1'b0, 1'b0);
    total++;
    if (a_stall_viol !== 0 || a_timeout !== 0) begin
      bad++;
      $display("FAIL stall_hold: got %0d active cycles want 0", a_stall_viol);
    end
    n = got_q.size();
    total++;
    if (n !== 8) begin
      bad++;
      $display("FAIL stall_count: got %0d want 8", n);
    end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++;
      if (got_q[i] !== e) begin
        bad++;
        $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], e);
      end
    end
    total++;
    if (chain_a !== exp_chain()) begin
      bad++;
      $display("FAIL stall_chain: got %h want %h", chain_a, exp_chain());
    end
  endtask

  task automatic test_abort();
    int c0;
    int extra = 0;
    for (int i = 0; i < 8; i++) a_words[i] = 8'hC3 ^ 8'(i);
    load_a(1'b1, 0, 1'b0, 1'b0, 1'b1);
    total++;
    if ({a_in_ready, a_rb_valid, a_rb_data, a_head, a_shift_en, a_busy, a_done} !== 14'h0) begin
      bad++;
      $display("FAIL abort_outputs: got %h want 0",
               {a_in_ready, a_rb_valid, a_rb_data, a_head, a_shift_en, a_busy, a_done});
    end
    a_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_shift_en || a_busy) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", extra);
    end
    for (int i = 0; i < 8; i++) a_words[i] = 8'h5A + 8'(3 * i);
    c0 = a_shift_cnt;
    load_a(1'b0, 0, 1'b0, 1'b0, 1'b0);
    total++;
    if (a_shift_cnt - c0 !== 64 || a_timeout !== 0) begin
      bad++;
      $display("FAIL abort_reload_shifts: got %0d want 64", a_shift_cnt - c0);
    end
    total++;
    if (chain_a !== exp_chain()) begin
      bad++;
      $display("FAIL abort_reload_chain: got %h want %h", chain_a, exp_chain());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    int relaunch = 0;
    for (int i = 0; i < 8; i++) a_words[i] = 8'($urandom_range(0, 255));
    c0 = a_shift_cnt;
    load_a(1'b0, 0, 1'b1, 1'b1, 1'b0);
    total++;
    if (a_shift_cnt - c0 !== 64 || a_timeout !== 0) begin
      bad++;
      $display("FAIL extra_start_shifts: got %0d want 64", a_shift_cnt - c0);
    end
    total++;
    if (chain_a !== exp_chain()) begin
      bad++;
      $display("FAIL extra_start_chain: got %h want %h", chain_a, exp_chain());
    end
    for (int i = 0; i < 10; i++) begin
      if (a_busy || a_shift_en) relaunch++;
      @(negedge clk);
    end
    total++;
    if (relaunch !== 0) begin
      bad++;
      $display("FAIL extra_start_ignored: got %0d busy cycles want 0", relaunch);
    end
  endtask

  initial begin
    a_reset = 1'b1; a_start = 1'b0; a_mode = 1'b0; a_in_data = '0;
    a_in_valid = 1'b0; a_rb_ready = 1'b1;
    b_reset = 1'b1; b_start = 1'b0; b_mode = 1'b0; b_in_data = '0;
    b_in_valid = 1'b0; b_rb_ready = 1'b1;
    test_reset();
    test_two_chains();
    test_stream();
    test_readback();
    test_rb_stall();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
